// File: rtl/set_region_counter_if.sv
// Bus bundle for set_region_counter: job configuration in, status and result out.
// Handshake: en is a one-cycle start pulse honoured only while the engine is idle
// (busy=0 and not in the result cycle); valid is a one-cycle strobe with candidate
// already updated, and there is no back-pressure on the result.
interface set_region_counter_if #(
  parameter int NCIRC = 3,
  parameter int CW    = 4,
  parameter int CNT_W = 7
);
  logic                     en;
  logic [2*CW*NCIRC-1:0]    central;
  logic [CW*NCIRC-1:0]      radius;
  logic [(1<<NCIRC)-1:0]    func;
  logic                     busy;
  logic                     valid;
  logic [CNT_W-1:0]         candidate;
  logic [1:0]               dbg_state;

  modport master (
    output en, central, radius, func,
    input  busy, valid, candidate, dbg_state
  );

  modport slave (
    input  en, central, radius, func,
    output busy, valid, candidate, dbg_state
  );
endinterface

// File: rtl/set_region_counter.sv
// Scans a G x G lattice one point per clock, classifies each point against NCIRC
// circles and counts the points whose membership vector selects a 1 in func.
module set_region_counter #(
  parameter int GRID_W = 3,
  parameter int NCIRC  = 3,
  parameter int CW     = 4,
  parameter int CNT_W  = 2*GRID_W+1
) (
  input  logic clk,
  input  logic rst,
  set_region_counter_if.slave bus
);
  localparam int G  = 1 << GRID_W;
  localparam int PW = GRID_W + 1;
  localparam int DW = CW + 2;
  localparam int SW = 2*CW + 3;
  localparam int NF = 1 << NCIRC;
  localparam logic [PW-1:0] GMAX = PW'(G);
  localparam logic [PW-1:0] ONE  = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          x_q, x_d, y_q, y_d;
  logic                   drain_q, drain_d;
  logic [2*CW*NCIRC-1:0]  cen_q, cen_d;
  logic [CW*NCIRC-1:0]    rad_q, rad_d;
  logic [NF-1:0]          func_q, func_d;
  logic [SW-1:0]          dist_q [NCIRC];
  logic [SW-1:0]          dist_d [NCIRC];
  logic [SW-1:0]          r2_q   [NCIRC];
  logic [SW-1:0]          r2_d   [NCIRC];
  logic                   s1_v_q, s1_v_d;
  logic [CNT_W-1:0]       acc_q, acc_d, cand_q, cand_d;
  logic [NCIRC-1:0]       memb;
  logic [DW-1:0]          dx  [NCIRC];
  logic [DW-1:0]          dy  [NCIRC];
  logic [DW-1:0]          adx [NCIRC];
  logic [DW-1:0]          ady [NCIRC];

  // Stage 1: squared distance of the current point to every centre, plus r^2.
  // Differences are two's complement; squaring the magnitude keeps it unsigned.
  always_comb begin
    for (int i = 0; i < NCIRC; i++) begin
      dx[i]     = DW'(x_q) - DW'(cen_q[2*CW*i+CW +: CW]);
      dy[i]     = DW'(y_q) - DW'(cen_q[2*CW*i +: CW]);
      adx[i]    = dx[i][DW-1] ? -dx[i] : dx[i];
      ady[i]    = dy[i][DW-1] ? -dy[i] : dy[i];
      dist_d[i] = SW'(adx[i]) * SW'(adx[i]) + SW'(ady[i]) * SW'(ady[i]);
      r2_d[i]   = SW'(rad_q[CW*i +: CW]) * SW'(rad_q[CW*i +: CW]);
    end
  end

  // Stage 2: boundary points (dist^2 == r^2) count as inside.
  always_comb begin
    for (int i = 0; i < NCIRC; i++) begin
      memb[i] = (dist_q[i] <= r2_q[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    drain_d = drain_q;
    cen_d   = cen_q;
    rad_d   = rad_q;
    func_d  = func_q;
    s1_v_d  = 1'b0;
    acc_d   = acc_q;
    cand_d  = cand_q;

    if (s1_v_q && func_q[memb]) begin
      acc_d = acc_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          state_d = S_SCAN;
          cen_d   = bus.central;
          rad_d   = bus.radius;
          func_d  = bus.func;
          acc_d   = '0;
        end
      end
      S_SCAN: begin
        s1_v_d = 1'b1;
        // y runs fastest; the generator wraps back to (1,1) on the last point.
        if (y_q == GMAX) begin
          y_d = ONE;
          if (x_q == GMAX) begin
            x_d     = ONE;
            state_d = S_DRAIN;
            drain_d = 1'b0;
          end else begin
            x_d = x_q + ONE;
          end
        end else begin
          y_d = y_q + ONE;
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = S_OUT;
          cand_d  = acc_q;
        end
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= ONE;
      y_q     <= ONE;
      drain_q <= 1'b0;
      cen_q   <= '0;
      rad_q   <= '0;
      func_q  <= '0;
      s1_v_q  <= 1'b0;
      acc_q   <= '0;
      cand_q  <= '0;
      for (int i = 0; i < NCIRC; i++) begin
        dist_q[i] <= '0;
        r2_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      drain_q <= drain_d;
      cen_q   <= cen_d;
      rad_q   <= rad_d;
      func_q  <= func_d;
      s1_v_q  <= s1_v_d;
      acc_q   <= acc_d;
      cand_q  <= cand_d;
      for (int i = 0; i < NCIRC; i++) begin
        dist_q[i] <= dist_d[i];
        r2_q[i]   <= r2_d[i];
      end
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.valid     = (state_q == S_OUT);
  assign bus.candidate = cand_q;
  assign bus.dbg_state = state_q;
endmodule

// File: doc/set_region_counter.md
# set_region_counter

Parametrised successor to the three-circle set-counting engine. It scans a square lattice of G×G points, where G = 2^GRID_W, and evaluates membership of each point in NCIRC circles in parallel, one point per clock. It applies an arbitrary Boolean set function, given as a truth table, to the membership vector and reports how many points satisfy it. Legacy modes (A, A−B, A⊕B, exactly-two-of-three) become particular truth-table values.

## Interface
Parameters:
- GRID_W, default 3: lattice coordinate bits; G = 2^GRID_W points per axis; coordinates run 1..G.
- NCIRC, default 3: number of circles, 1..4.
- CW, default 4: width of each centre coordinate and radius field (unsigned).
- CNT_W, default 2*GRID_W+1: width of the count; must hold G².

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  job start; single-cycle pulse, sampled only in IDLE.
- central  in  2*CW*NCIRC  per circle i, {x,y} at bits [2*CW*(i+1)-1 : 2*CW*i], x in the upper half.
- radius  in  CW*NCIRC  radius of circle i at [CW*(i+1)-1 : CW*i].
- func  in  2^NCIRC  truth table; a point counts iff func[m]=1, where m[i] = point inside circle i.
- busy  out  1  high from the cycle after en is accepted through the OUT cycle inclusive.
- valid  out  1  one-cycle result strobe.
- candidate  out  CNT_W  result of the last completed job.

## Operation
- On en in IDLE, capture central, radius and func into registers. Inputs may change afterwards without effect.
- FSM states: IDLE → SCAN → DRAIN → OUT → IDLE.
  - IDLE: wait for en.
  - SCAN: exactly G² cycles. A point generator steps y fastest, then x, from (1,1) to (G,G), then leaves SCAN.
  - DRAIN: 2 cycles, to flush the pipeline.
  - OUT: 1 cycle.
- Pipeline, per point:
  - Stage 1 registers per-circle dx² + dy², with dx = x − cx and dy = y − cy, plus r².
  - Stage 2 compares and forms m, looks up func[m], and increments the accumulator if set.
- Arithmetic:
  - Differences are signed, CW+2 bits.
  - Squares and sums are unsigned, 2*CW+3 bits, with no truncation.
  - Inside test is dist² ≤ r², so boundary points are inside.
  - r = 0 includes only the centre point.
  - A centre outside 1..G is legal; only on-grid points are counted.
- The accumulator clears on job acceptance. It cannot overflow, because the maximum is G².
- Accepting a job does not change candidate until OUT. In OUT, candidate takes the accumulator value and holds it until the next OUT or reset.
- en while busy is ignored, with no queuing. en asserted in the OUT cycle is also ignored. en in the first IDLE cycle after OUT is accepted.
- Unused func entries are not possible; all 2^NCIRC entries are significant.

## Timing
- Reset values: busy=0, valid=0, candidate=0; FSM in IDLE; point generator at (1,1); accumulator 0.
- en is sampled at edge E.
  - busy=1 from E until edge E+G²+3.
  - SCAN occupies cycles E..E+G²−1.
  - DRAIN occupies cycles E+G²..E+G²+1.
  - valid=1 in cycle E+G²+2 only, with candidate already updated in that cycle.
  - busy=0 from E+G²+3.
- Total job latency is G²+3 cycles; for the defaults that is 67.
- Reset asserted mid-job aborts immediately. All state returns to its reset value, candidate becomes 0, and no valid is produced.
- Back-to-back jobs: the minimum en spacing is G²+4 cycles.

## Test plan
- Defaults, A = (4,4) r=2, func=8'hAA (A only) → valid at en+66 cycles, candidate=13, busy high for 67 cycles.
- A = B = (4,4) r=2, C far away, func=8'h66 (A⊕B) → candidate=0; same circles with func=8'hFF → candidate=64; func=8'h00 → candidate=0.
- A = (1,1) r=0 with func=8'hAA → candidate=1; A = (0,0) r=0 → candidate=0 (off-grid centre); A = (4,4) r=15 → candidate=64.
- Exactly-two-of-three: A = (3,3), B = (5,3), C = (4,5), all r=2, func=8'h68 → candidate equals the software model count. Run 500 random circles and func values against the model.
- Hold en high for 100 cycles → exactly one job, then a second job starts in the first IDLE cycle. The previous candidate is held between the two valid strobes.
- Assert rst at SCAN cycle 20 → busy=0, valid=0, candidate=0 immediately. A following job gives the correct result.
